// File: rtl/xadc_scheduler_pkg.sv
// Shared station-system definitions for the XADC DRP scheduler: FSM encoding,
// default channel addresses and the on-chip temperature scale.
package xadc_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDeliver
    } state_e;

    localparam logic [6:0] DefCh0Addr = 7'h00;  // on-chip temperature
    localparam logic [6:0] DefCh1Addr = 7'h03;  // VP/VN
    localparam logic [6:0] DefCh2Addr = 7'h10;  // VAUX0
    localparam logic [6:0] DefCh3Addr = 7'h11;  // VAUX1

    localparam int unsigned TempCountsPerDeg = 68;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/xadc_scheduler_rr_arbiter.sv
// Combinational 4-way round-robin arbiter; search starts just above last_served.
module rr_arbiter (
    input  logic [3:0] req,
    input  logic [1:0] last_served,
    output logic [3:0] grant
);

    logic [1:0] shift;
    logic [7:0] rotated;
    logic [3:0] lowest;
    logic [7:0] restored;

    // Rotate so the highest-priority requester sits at bit 0, take the lowest
    // set bit, then rotate that one-hot back into place.
    always_comb begin
        shift    = last_served + 2'd1;
        rotated  = {req, req} >> shift;
        lowest   = rotated[3:0] & (~rotated[3:0] + 4'd1);
        restored = {lowest, lowest} << shift;
        grant    = restored[7:4];
    end

endmodule

// File: rtl/xadc_scheduler.sv
// Round-robin scheduler sharing one XADC DRP read port among four requesters,
// with a saturating drdy timeout.
module xadc_scheduler
    import xadc_scheduler_pkg::*;
#(
    parameter logic [6:0]  CH0_ADDR = DefCh0Addr,
    parameter logic [6:0]  CH1_ADDR = DefCh1Addr,
    parameter logic [6:0]  CH2_ADDR = DefCh2Addr,
    parameter logic [6:0]  CH3_ADDR = DefCh3Addr,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        ACLK,
    input  logic        reset,
    input  logic [3:0]  req,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [11:0] result,
    output logic        err,
    output logic [6:0]  daddr,
    output logic        den,
    input  logic        drdy,
    input  logic [15:0] do_in
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [3:0]      arb_grant;
    logic [3:0]      grant_q;
    logic [1:0]      last_q;
    logic [CntW-1:0] cnt_q;
    logic [11:0]     result_q;
    logic            err_q;
    logic [6:0]      daddr_q;
    logic [6:0]      chan_addr;
    logic            timed_out;
    logic            unused_do;

    assign unused_do = ^do_in[3:0];
    assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

    rr_arbiter u_arb (
        .req         (req),
        .last_served (last_q),
        .grant       (arb_grant)
    );

    always_comb begin
        chan_addr = CH0_ADDR;
        case (onehot_to_idx(arb_grant))
            2'd0:    chan_addr = CH0_ADDR;
            2'd1:    chan_addr = CH1_ADDR;
            2'd2:    chan_addr = CH2_ADDR;
            default: chan_addr = CH3_ADDR;
        endcase
    end

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (|req) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (drdy || timed_out) state_d = StDeliver;
            StDeliver: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            grant_q  <= '0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            daddr_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        grant_q <= arb_grant;
                        daddr_q <= chan_addr;
                    end
                end
                StIssue: cnt_q <= '0;
                StWait: begin
                    if (cnt_q != CntW'(TIMEOUT)) cnt_q <= cnt_q + CntW'(1);
                    // drdy wins over a timeout landing in the same cycle
                    if (drdy) begin
                        result_q <= do_in[15:4];
                        err_q    <= 1'b0;
                    end else if (timed_out) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                StDeliver: begin
                    last_q  <= onehot_to_idx(grant_q);
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        den  = (state_q == StIssue);
        done = (state_q == StDeliver) ? grant_q : 4'b0000;
        err  = (state_q == StDeliver) && err_q;
    end

    assign grant  = grant_q;
    assign result = result_q;
    assign daddr  = daddr_q;

endmodule

// File: tb/tb_xadc_scheduler.sv
// Bench for xadc_scheduler: a DRP responder, a transaction-level model checked
// every cycle, and directed scenarios with literal expectations.
module tb_xadc_scheduler;

    localparam int Timeout = 255;

    logic        ACLK = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [11:0] result;
    logic        err;
    logic [6:0]  daddr;
    logic        den;
    logic        drdy;
    logic [15:0] do_in;

    int          checks   = 0;
    int          failures = 0;
    int          drdy_delay = 2;          // 0 = responder never answers
    logic [15:0] drdy_base  = 16'h6A40;
    logic [6:0]  ch_addr [4] = '{7'h00, 7'h03, 7'h10, 7'h11};

    always #5 ACLK = ~ACLK;

    xadc_scheduler dut (
        .ACLK   (ACLK),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .done   (done),
        .result (result),
        .err    (err),
        .daddr  (daddr),
        .den    (den),
        .drdy   (drdy),
        .do_in  (do_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] resp_data(input logic [6:0] a);
        return drdy_base ^ {a, 9'h000};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return 0;
    endfunction

    function automatic int oh_idx(input logic [3:0] oh);
        int idx = -1;
        for (int i = 0; i < 4; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    // DRP responder: answers each den after drdy_delay cycles.
    initial begin
        int          rcnt;
        logic [15:0] rdata;
        rcnt  = 0;
        rdata = '0;
        drdy  = 1'b0;
        do_in = 16'hDEAD;
        forever begin
            @(negedge ACLK);
            if (den) begin
                rcnt  = drdy_delay;
                rdata = resp_data(daddr);
            end
            @(posedge ACLK);
            #1;
            drdy  = 1'b0;
            do_in = 16'hDEAD;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    drdy  = 1'b1;
                    do_in = rdata;
                end
            end
        end
    end

    // Transaction-level model: who wins, when done must land, what it carries.
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_idle_prev = 0;
    logic [3:0]  m_req_prev = '0;
    int          m_last = 3;
    int          m_win = 0;
    int          m_done_at = 0;
    int          m_last_den = -1;
    logic [11:0] m_res = '0;
    logic [11:0] m_held = '0;
    logic        m_err = 1'b0;
    logic [6:0]  m_daddr = '0;

    always @(negedge ACLK) begin : mon
        bit          exp_den;
        bit          busy_now;
        bit          deliver;
        logic [15:0] full;
        cyc++;
        if (reset) begin
            chk("reset_outputs", {grant, done, den, err, result, daddr}, '0);
            m_busy      = 0;
            m_idle_prev = 0;
            m_last      = 3;
            m_held      = '0;
            m_last_den  = -1;
        end else begin
            exp_den = m_idle_prev && (m_req_prev != 4'b0000);
            if (exp_den) begin
                m_win   = rr_pick(m_req_prev, m_last);
                m_daddr = ch_addr[m_win];
                m_busy  = 1;
                if (m_last_den >= 0) chk("den_spacing", 32'(cyc - m_last_den >= 4), 1);
                m_last_den = cyc;
                if (drdy_delay >= 1 && drdy_delay <= Timeout) begin
                    m_done_at = cyc + drdy_delay + 1;
                    full      = resp_data(m_daddr);
                    m_res     = full[15:4];
                    m_err     = 1'b0;
                end else begin
                    m_done_at = cyc + Timeout + 1;
                    m_res     = '0;
                    m_err     = 1'b1;
                end
            end
            busy_now = m_busy;
            deliver  = m_busy && (cyc == m_done_at);
            chk("model_den", den, exp_den);
            chk("model_grant", grant, busy_now ? (1 << m_win) : 0);
            if (busy_now) chk("model_daddr", daddr, m_daddr);
            chk("model_done", done, deliver ? (1 << m_win) : 0);
            if (deliver) begin
                m_held = m_res;
                chk("model_err", err, m_err);
                m_last = m_win;
                m_busy = 0;
            end
            chk("model_result", result, m_held);
            m_idle_prev = !busy_now;
        end
        m_req_prev = req;
    end

    task automatic wait_den();
        int k = 0;
        do begin
            @(negedge ACLK);
            k++;
        end while (!den && k < 50);
        chk("wait_den", den, 1);
    endtask

    task automatic wait_done(input logic [3:0] mask, output int n);
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(|(done & mask)) && n < 400);
        chk("wait_done", 32'(|(done & mask)), 1);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt1;
        int order [8];
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_den", den, 0);
        chk("rst_result", result, 12'h000);
        chk("rst_daddr", daddr, 7'h00);
        reset = 1'b0;

        // Single request on the temperature channel
        drdy_delay = 3;
        drdy_base  = 16'h6A40;
        req        = 4'b0001;
        wait_den();
        chk("t1_daddr_at_den", daddr, 7'h00);
        wait_done(4'b0001, n);
        chk("t1_den_to_done", n, 4);
        chk("t1_done", done, 4'b0001);
        chk("t1_result", result, 12'h6A4);
        chk("t1_err", err, 0);
        step();
        req = 4'b0000;
        step();

        // Temperature step 25 C -> 40 C
        drdy_base = 16'hAA00;
        req       = 4'b0001;
        wait_done(4'b0001, n);
        chk("t2_result", result, 12'hAA0);
        step();
        req = 4'b0000;

        // All four continuously after a fresh reset
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        drdy_delay = 2;
        req        = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_done(4'b1111, n);
            order[i] = oh_idx(done);
        end
        step();
        req = 4'b0000;
        for (int i = 0; i < 8; i++) chk("t3_order", order[i], exp_order[i]);

        // Timeout on requester 0, then requester 2 is served
        drdy_delay = 0;
        req        = 4'b0101;
        wait_den();
        chk("t4_daddr", daddr, 7'h00);
        wait_done(4'b1111, n);
        chk("t4_den_to_done", n, 256);
        chk("t4_done", done, 4'b0001);
        chk("t4_err", err, 1);
        chk("t4_result", result, 12'h000);
        step();
        drdy_delay = 2;
        req        = 4'b0100;
        wait_done(4'b1111, n);
        chk("t4_next_done", done, 4'b0100);
        chk("t4_next_err", err, 0);
        step();
        req = 4'b0000;
        step();

        // Drop after grant completes; drop before grant is skipped
        req = 4'b0010;
        wait_done(4'b0010, n);
        step();
        req = 4'b0000;
        step();
        req = 4'b0110;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!grant[2] && n < 50);
        chk("t5_grant", grant, 4'b0100);
        step();
        req = 4'b0000;
        wait_done(4'b1111, n);
        chk("t5_done2", done, 4'b0100);
        cnt1 = 0;
        repeat (20) begin
            @(negedge ACLK);
            if (done[1]) cnt1++;
        end
        chk("t5_skip1", cnt1, 0);

        // Reset in the middle of WAIT; the late drdy must be ignored
        step();
        drdy_delay = 5;
        req        = 4'b0100;
        wait_den();
        @(negedge ACLK);
        @(negedge ACLK);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_daddr", daddr, 7'h00);
        chk("t6_rst_result", result, 12'h000);
        chk("t6_rst_done_den_err", {done, den, err}, 6'b000000);
        req = 4'b0000;
        step();
        step();
        reset = 1'b0;
        cnt1  = 0;
        repeat (12) begin
            @(negedge ACLK);
            if (done != 4'b0000) cnt1++;
        end
        chk("t6_no_done", cnt1, 0);
        step();
        drdy_delay = 2;
        req        = 4'b1111;
        wait_done(4'b1111, n);
        chk("t6_first_winner", done, 4'b0001);
        step();
        req = 4'b0000;
        repeat (5) @(negedge ACLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xadc_scheduler.md
XADC_SCHEDULER -- requirements
Module: xadc_scheduler

Interface
REQ-001 Parameter CH0_ADDR, default 7'h00, DRP address serviced for requester 0 (on-chip temperature).
REQ-002 Parameter CH1_ADDR, default 7'h03, DRP address for requester 1 (VP/VN).
REQ-003 Parameter CH2_ADDR, default 7'h10, DRP address for requester 2 (VAUX0).
REQ-004 Parameter CH3_ADDR, default 7'h11, DRP address for requester 3 (VAUX1).
REQ-005 Parameter TIMEOUT, default 255, maximum cycles to wait for drdy.
REQ-006 ACLK  input  1  single system clock; all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req  input  4  per-requester conversion request, level, bit i = requester i.
REQ-009 grant  output  4  one-hot, high while requester i owns the XADC.
REQ-010 done  output  4  one-cycle pulse to requester i when its result is valid.
REQ-011 result  output  12  conversion result, valid in the done cycle, held until the next done.
REQ-012 err  output  1  high in a done cycle if that transaction timed out.
REQ-013 daddr  output  7  DRP address to the XADC.
REQ-014 den  output  1  DRP enable, one-cycle pulse per read.
REQ-015 drdy  input  1  DRP data ready from the XADC.
REQ-016 do_in  input  16  DRP read data; result = do_in[15:4].

Function
REQ-017 States: IDLE, ISSUE, WAIT, DELIVER; IDLE is the reset state.
REQ-018 IDLE: if any req bit is high, select the winner, set grant, load daddr, and go to ISSUE next cycle; else stay in IDLE.
REQ-019 Arbitration: round-robin, searching from (last_served+1) mod 4 upward; last_served resets to 3, so requester 0 wins first.
REQ-020 ISSUE: den=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-021 WAIT: on drdy, register do_in[15:4] into result, err=0, then go to DELIVER; drdy in the same cycle as den is ignored.
REQ-022 WAIT: timeout counter increments each cycle; when it reaches TIMEOUT without drdy, result=0, err=1, then go to DELIVER.
REQ-023 DELIVER: done[winner]=1 for one cycle, update last_served=winner, clear grant, then return to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N, den at N+1, drdy at N+1+k (k≥1), done at N+2+k.
REQ-025 Minimum spacing between successive den pulses: 4 cycles.
REQ-026 Requesters hold req until done; a req dropped before grant is simply not served.
REQ-027 A req dropped after grant does not abort; the transaction completes and done still pulses.
REQ-028 Simultaneous requests from all four requesters are served in rotation order; no requester waits more than 3 transactions.
REQ-029 A req held high after done re-enters arbitration normally (no back-to-back starvation of others).
REQ-030 Timeout counter width is $clog2(TIMEOUT+1); it saturates and does not wrap.
REQ-031 daddr is held stable from ISSUE through DELIVER.

Reset
REQ-032 Reset asserted at any time, including mid-WAIT, forces within the same edge: state=IDLE, grant=0, done=0, den=0, err=0, result=0, daddr=0, last_served=3, and the timeout counter to 0.
REQ-033 A drdy arriving after reset is released is ignored while the block is in IDLE.

Structure
REQ-034 State encodings, default DRP channel addresses, and the 68-counts-per-degree temperature scale constant belong in the shared station-system package.
REQ-035 One sub-module, rr_arbiter (4-bit request, last_served in, one-hot grant out, combinational), is natural; the FSM and timeout logic stay in xadc_scheduler.

Verification
REQ-036 Single request: req=4'b0001, drdy 3 cycles after den with do_in=16'h6A40 (1700 = 25 °C) -> daddr=7'h00, done[0] pulses once, result=12'h6A4, err=0.
REQ-037 All four req high continuously, drdy always 2 cycles after den -> done order 0,1,2,3,0,…; each den pulse has the matching CHx_ADDR.
REQ-038 drdy never asserted, TIMEOUT=255 -> done[winner] occurs 256 cycles after den with err=1 and result=0, then the next requester is served.
REQ-039 req[2] dropped one cycle after grant[2] -> done[2] still pulses; req[1] dropped before grant -> requester 1 is skipped.
REQ-040 reset asserted mid-WAIT, then drdy pulses -> all outputs 0 immediately, no done, the next request goes to requester 0.
REQ-041 Temperature step: requester 0 reads do_in=16'h6A40, then 16'hAA00 (2720 = 40 °C) -> result changes 12'h6A4 to 12'hAA0 with one done each.
